// File: rtl/k2red_unscale.sv
// Domain exit for K2-RED: X = T * kinv2 mod q, computed with a bit-serial interleaved
// modular multiplier that consumes one bit of kinv2 per cycle, starting at the MSB.
module k2red_unscale #(
  parameter int LOGQ = 32,
  parameter int LOGC = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  output logic            ready_in,
  input  logic [LOGQ-1:0] T,
  input  logic [LOGQ-1:0] q,
  input  logic [LOGQ-1:0] kinv2,
  output logic            valid_out,
  input  logic            ready_out,
  output logic [LOGQ-1:0] X
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [LOGQ-1:0] t_r, q_r, k_r, acc;
  logic [LOGC-1:0] cnt;
  logic [LOGQ:0]   dbl, sum;
  logic [LOGQ-1:0] half, nxt;

  // acc, T < q keeps every intermediate below 2q, so a single conditional
  // subtract after the doubling and after the add is enough.
  always_comb begin
    dbl  = {acc, 1'b0};
    half = (dbl >= {1'b0, q_r}) ? LOGQ'(dbl - {1'b0, q_r}) : LOGQ'(dbl);
    sum  = {1'b0, half} + {1'b0, t_r & {LOGQ{k_r[LOGQ-1]}}};
    nxt  = (sum >= {1'b0, q_r}) ? LOGQ'(sum - {1'b0, q_r}) : LOGQ'(sum);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ready_in  <= 1'b1;
      valid_out <= 1'b0;
      X         <= '0;
      acc       <= '0;
      cnt       <= '0;
      t_r       <= '0;
      q_r       <= '0;
      k_r       <= '0;
    end else begin
      case (state)
        IDLE: if (valid_in) begin
          t_r      <= T;
          q_r      <= q;
          k_r      <= kinv2;
          acc      <= '0;
          cnt      <= LOGC'(LOGQ - 1);
          ready_in <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          acc <= nxt;
          // multiplier bits are shifted out of the top so no variable index is needed
          k_r <= {k_r[LOGQ-2:0], 1'b0};
          if (cnt == '0) begin
            X         <= nxt;
            valid_out <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: if (ready_out) begin
          valid_out <= 1'b0;
          ready_in  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_k2red_unscale.sv
// Scoreboard bench for k2red_unscale: stimulus pushes T*kinv2 mod q, a monitor pops on
// every output handshake; directed checks cover latency, backpressure and reset abort.
module tb_k2red_unscale;
  localparam logic [31:0] QF = 32'd2148794369;

  logic        clk = 1'b0, rst = 1'b0, valid_in = 1'b0, ready_out = 1'b0;
  logic [31:0] T = '0, q = '0, kinv2 = '0;
  logic        ready_in, valid_out;
  logic [31:0] X;

  k2red_unscale #(.LOGQ(32), .LOGC(6)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
    .T(T), .q(q), .kinv2(kinv2),
    .valid_out(valid_out), .ready_out(ready_out), .X(X)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] sb[$];
  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] t, k, m);
    longint unsigned a, b, c;
    a = t; b = k; c = m;
    return 32'((a * b) % c);
  endfunction

  always @(negedge clk)
    if (rst && valid_out && ready_out) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result: got %0d want none", X);
      end else chk("result", X, sb.pop_front());
    end

  task automatic send(input logic [31:0] t, k, m, output int acc_cyc);
    bit got = 0;
    T = t; kinv2 = k; q = m; valid_in = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk); got = ready_in;
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout: got ready_in=0 want 1");
    end else sb.push_back(model(t, k, m));
    acc_cyc = cyc;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 300 && sb.size() != 0; n++) @(posedge clk);
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int a, input string name);
    while (!valid_out && cyc - a < 40) begin @(posedge clk); #1; end
    chk(name, cyc - a, 32);
  endtask

  task automatic run_one(input logic [31:0] t, k, m, exp_x, input string name);
    int a;
    send(t, k, m, a);
    wait_valid(a, {name, "_latency"});
    wait_drain();
    chk({name, "_X"}, X, exp_x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int acc[4];
    logic [31:0] rt, rk, rq;

    repeat (2) @(posedge clk); #1;
    chk("reset_valid_out", valid_out, 0);
    chk("reset_X", X, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready_in", ready_in, 1);

    // identity, then backpressure with a busy-time operand on the input
    ready_out = 1'b0;
    send(32'd1965696994, 32'd1, QF, a);
    wait_valid(a, "s1_latency");
    T = 32'd777; kinv2 = 32'd5; q = QF; valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_out", valid_out, 1);
      chk("bp_X", X, 32'd1965696994);
      chk("bp_ready_in", ready_in, 0);
    end
    ready_out = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid_out", valid_out, 0);
    chk("bp_release_ready_in", ready_in, 1);
    @(posedge clk); #1;
    chk("pending_taken", ready_in, 0);
    sb.push_back(model(32'd777, 32'd5, QF));
    valid_in = 1'b0;
    wait_drain();
    chk("pending_X", X, 32'd3885);

    run_one(QF - 1, 32'd2, QF, 32'd2148794367, "s2");
    run_one(QF - 1, QF - 1, QF, 32'd1, "s3max");
    run_one(32'd0, 32'd12345, QF, 32'd0, "s3zero");

    // back-to-back stream, fixed q
    for (int i = 0; i < 4; i++) begin
      rt = $urandom % QF; rk = $urandom % QF;
      send(rt, rk, QF, acc[i]);
      if (i > 0) chk("spacing", acc[i] - acc[i-1], 34);
    end
    wait_drain();

    // random odd moduli
    for (int i = 0; i < 4; i++) begin
      rq = $urandom | 32'h8000_0001;
      rt = $urandom % rq; rk = $urandom % rq;
      send(rt, rk, rq, a);
    end
    wait_drain();

    // reset in the middle of RUN
    send(QF - 5, QF - 7, QF, a);
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("rst_mid_valid_out", valid_out, 0);
    chk("rst_mid_X", X, 0);
    #10 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready_in", ready_in, 1);
    run_one(QF - 1, 32'd2, QF, 32'd2148794367, "s5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/k2red_unscale.md
Name: k2red_unscale

Overview:
- Domain-exit unit for the K2-RED datapath. K2-RED leaves results scaled as T = k^2·x mod q; this block recovers x = T·kinv2 mod q, where kinv2 = k^-2 mod q is supplied by the host.
- Bit-serial interleaved modular multiplier: one multiplier bit per cycle, LOGQ cycles per operand.
- Valid/ready handshakes on both sides. Sits after k2red_shift on the output path to the host.

Parameters:
- LOGQ, 32, bit width of q, T, kinv2 and X.
- LOGC, 6, counter width; must satisfy 2^LOGC >= LOGQ.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- valid_in  input  1  T/q/kinv2 are valid this cycle.
- ready_in  output  1  block can accept an operand; high only in IDLE.
- T  input  LOGQ  K2-domain value; must be < q.
- q  input  LOGQ  full modulus (q = k·2^m + 1); must be odd and > 2.
- kinv2  input  LOGQ  k^-2 mod q; must be < q.
- valid_out  output  1  X holds a result.
- ready_out  input  1  downstream accepts X this cycle.
- X  output  LOGQ  T·kinv2 mod q, in [0, q-1].

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, valid_out=0, X=0, accumulator=0, counter=0; ready_in=1 once rst is released.
- States and transitions:
  - IDLE: ready_in=1. On valid_in=1, latch T, q and kinv2 into internal registers, clear the accumulator, set counter=LOGQ-1, go to RUN.
  - RUN: one step per cycle for bit i = counter, MSB first:
    - a = 2·acc; if a >= q then a = a - q.
    - if kinv2[i] then b = a + T, else b = a; if b >= q then b = b - q.
    - acc = b.
    - When counter=0: X <= b, valid_out <= 1, go to DONE. Otherwise counter decrements.
  - DONE: valid_out=1, X held stable. On ready_out=1, valid_out <= 0, go to IDLE. X keeps its value until the next result or a reset.
- Widths: intermediates are LOGQ+1 bits; one conditional subtract per half-step is sufficient because acc, T < q. Inputs outside range (T >= q, kinv2 >= q) give an unspecified result; the block does not check them.
- Latency: from the accept edge (valid_in and ready_in both high) to valid_out=1 is exactly LOGQ cycles. Minimum initiation interval is LOGQ+2 cycles (DONE handshake cycle, then IDLE).
- Inputs change freely after acceptance; only the latched copies are used.
- valid_in while busy (RUN or DONE) is ignored; ready_in=0, so the handshake has not occurred. The sender must hold the operand until ready_in is high.
- Backpressure: in DONE with ready_out=0 the block stalls indefinitely with X and valid_out constant.
- Reset mid-RUN or mid-DONE aborts the operation; the result is discarded and all outputs return to their reset values immediately.
- kinv2=0 or T=0 gives X=0 after the full LOGQ cycles; there is no early exit.

Test Plan:
1. Identity: q=2148794369, kinv2=1, T=1965696994 -> valid_out rises exactly 32 cycles after accept, X=1965696994.
2. Doubling wrap: q=2148794369, kinv2=2, T=2148794368 -> X=2148794367.
3. Max operands: q=2148794369, T=2148794368, kinv2=2148794368 -> X=1. Zero operand: T=0, kinv2=12345 -> X=0 after 32 cycles.
4. Backpressure and busy input: after scenario 1 hold ready_out=0 for 5 cycles while driving valid_in=1 with new data -> X and valid_out stable, ready_in=0, new data not taken. Raise ready_out -> valid_out drops the next cycle, ready_in=1, and the pending operand is accepted.
5. Reset mid-RUN: pull rst low 10 cycles after accept -> valid_out=0 and X=0 immediately. After release, ready_in=1 and a fresh scenario-2 operand gives the correct result.
6. Back-to-back: 4 random operands (T, kinv2 < q, q=2148794369) streamed with ready_out=1 -> each X equals T·kinv2 mod q against the reference model, spacing 34 cycles.
